// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types and constants for the clock divider scheduler
package clkdiv_pkg;

    // Controller states: IDLE (stopped), RUN (dividing), STOP (finishing current period)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    // Smallest ratio the divider can produce
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clkdiv_core.sv
// rtl/clkdiv_core.sv - period counter with registered divided output and tick
module clkdiv_core #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         active_i,
    input  logic         run_next_i,
    input  logic [W-1:0] ratio_i,
    output logic         q_o,
    output logic         tick_o,
    output logic         bnd_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] half;
    logic         q_q;
    logic         tick_q;

    assign half   = ratio_i >> 1;
    assign bnd_o  = active_i && (cnt_q == (ratio_i - ONE));
    assign q_o    = q_q;
    assign tick_o = tick_q;

    // Count within the period; restart at the boundary and hold at zero while idle
    always_comb begin
        cnt_d = '0;
        if (active_i && !bnd_o) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // q and tick are derived from the next count so they line up with cnt.
    // A ratio change only happens when cnt_d is zero, where q is 1 for any
    // legal ratio, so comparing against the current ratio is safe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            q_q    <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= run_next_i && (cnt_d < half);
            tick_q <= run_next_i && (cnt_d == '0);
        end
    end

endmodule

// File: rtl/clkdiv_sched.sv
// rtl/clkdiv_sched.sv - glitch-free start/stop and ratio sequencing for the clock divider
module clkdiv_sched
    import clkdiv_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_val,
    input  logic         div_valid,
    output logic         div_ready,
    output logic         div_err,
    output logic         q,
    output logic         tick,
    output logic         busy,
    output logic [W-1:0] cur_div
);

    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MIN_N   = W'(MIN_DIV);

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] cur_div_q;
    logic [W-1:0] cur_div_d;
    logic [W-1:0] pend_div_q;
    logic [W-1:0] pend_div_d;
    logic         pend_vld_q;
    logic         pend_vld_d;
    logic         div_err_q;
    logic         div_err_d;
    logic         bnd;
    logic         accept;
    logic         apply;

    assign div_ready = ~pend_vld_q;
    assign div_err   = div_err_q;
    assign busy      = (state_q != IDLE);
    assign cur_div   = cur_div_q;
    assign accept    = div_valid && div_ready;
    assign apply     = pend_vld_q && ((state_q == IDLE) || bnd);

    clkdiv_core #(
        .W (W)
    ) u_core (
        .clk_i      (clk),
        .rst_i      (rst),
        .active_i   (state_q != IDLE),
        .run_next_i (state_d != IDLE),
        .ratio_i    (cur_div_q),
        .q_o        (q),
        .tick_o     (tick),
        .bnd_o      (bnd)
    );

    // Next state: start only once no ratio is pending, stop only at a period boundary
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en && !pend_vld_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = bnd ? IDLE : STOP;
                end
            end
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (bnd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request handshake and ratio application; accept and apply never coincide
    always_comb begin
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        div_err_d  = 1'b0;
        if (apply) begin
            cur_div_d  = pend_div_q;
            pend_vld_d = 1'b0;
        end
        if (accept) begin
            if (div_val < MIN_N) begin
                div_err_d = 1'b1;
            end else begin
                pend_div_d = div_val;
                pend_vld_d = 1'b1;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_div_q  <= DEF_DIV;
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            div_err_q  <= div_err_d;
        end
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// tb/tb_clkdiv_sched.sv - randomized bench for clkdiv_sched against a period-level model
module tb_clkdiv_sched;

    localparam int W   = 8;
    localparam int DEF = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div_val;
    logic         div_valid;
    logic         div_ready;
    logic         div_err;
    logic         q;
    logic         tick;
    logic         busy;
    logic [W-1:0] cur_div;

    clkdiv_sched #(
        .W           (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_val   (div_val),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_err   (div_err),
        .q         (q),
        .tick      (tick),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model: running flag, position within the period, period length, pending ratio
    int m_run;
    int m_pos;
    int m_len;
    int m_pend;
    int m_pdiv;
    int m_err;

    task automatic check_eq(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_pos  = 0;
        m_len  = DEF;
        m_pend = 0;
        m_pdiv = 0;
        m_err  = 0;
    endtask

    // Advance one clock using the inputs presented during that cycle
    task automatic model_step();
        int bnd;
        int acc;
        int app;
        int nrun;
        int npos;
        bnd  = (m_run != 0) && (m_pos == m_len - 1);
        acc  = (div_valid == 1'b1) && (m_pend == 0);
        app  = (m_pend != 0) && ((m_run == 0) || (bnd != 0));
        if (m_run != 0) nrun = !((bnd != 0) && (en == 1'b0));
        else            nrun = (en == 1'b1) && (m_pend == 0);
        npos = ((m_run != 0) && (bnd == 0)) ? m_pos + 1 : 0;
        m_err = (acc != 0) && (int'(div_val) < 2);
        if (app != 0) begin
            m_len  = m_pdiv;
            m_pend = 0;
        end
        if ((acc != 0) && (int'(div_val) >= 2)) begin
            m_pend = 1;
            m_pdiv = int'(div_val);
        end
        m_run = nrun;
        m_pos = npos;
    endtask

    task automatic check_outputs();
        check_eq("q",         int'(q),         (m_run != 0) && (m_pos < m_len / 2));
        check_eq("tick",      int'(tick),      (m_run != 0) && (m_pos == 0));
        check_eq("busy",      int'(busy),      m_run);
        check_eq("cur_div",   int'(cur_div),   m_len);
        check_eq("div_ready", int'(div_ready), (m_pend == 0) ? 1 : 0);
        check_eq("div_err",   int'(div_err),   m_err);
    endtask

    task automatic pick_div_val();
        int r;
        r = $urandom_range(0, 19);
        if (r < 3)        div_val = W'(r);
        else if (r < 19)  div_val = W'(2 + $urandom_range(0, 7));
        else              div_val = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'd9;
    endtask

    initial begin
        bit rst_done;
        rst_done  = 1'b0;
        rst       = 1'b1;
        en        = 1'b0;
        div_valid = 1'b0;
        div_val   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            if (i < 12) begin
                en        = 1'b1;
                div_valid = 1'b0;
            end else begin
                if ($urandom_range(0, 15) == 0) en = ~en;
                div_valid = ($urandom_range(0, 3) == 0);
                pick_div_val();
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();

            if (!rst_done && (((i >= 1500) && (m_run != 0) && (m_pos == 2)) || (i == 2500))) begin
                rst_done = 1'b1;
                rst = 1'b1;
                #1;
                check_eq("rst_q",       int'(q),         0);
                check_eq("rst_tick",    int'(tick),      0);
                check_eq("rst_busy",    int'(busy),      0);
                check_eq("rst_cur_div", int'(cur_div),   DEF);
                check_eq("rst_ready",   int'(div_ready), 1);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
